alu_share_arb: RTL and testbench
================================

# alu_share_arb

Two-requester arbiter and sequencer for the shared 32-bit integer ALU.
- Accepts operand/opcode requests over valid/ready handshakes and grants one at a time, round-robin.
- Registers the winning operands onto the ALU inputs and captures the ALU result into a response register tagged with the requester ID.
- Sits between the execute stage (requester 0) and the branch/address-compute path (requester 1), so both share one ALU instance.

## Interface
- DATA_W, 32, operand/result width
- OP_W, 4, ALU opcode width (shared opcode encoding)
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- req0_valid_i / req1_valid_i  in  1  request valid per requester
- req0_ready_o / req1_ready_o  out  1  request accepted this cycle when valid & ready
- req0_op1_i / req1_op1_i  in  DATA_W  operand 1
- req0_op2_i / req1_op2_i  in  DATA_W  operand 2
- req0_op_i / req1_op_i  in  OP_W  ALU opcode
- alu_operand1_o  out  DATA_W  registered operand 1 to ALU
- alu_operand2_o  out  DATA_W  registered operand 2 to ALU
- alu_op_o  out  OP_W  registered opcode to ALU
- alu_data_i  in  DATA_W  combinational ALU result
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  consumer accepts response
- rsp_data_o  out  DATA_W  captured result
- rsp_id_o  out  1  requester that issued the response

## Operation
- States: IDLE, EXEC, RESP.
- can_accept = (state==IDLE) | (state==RESP & rsp_ready_i).
- Grant:
  - Only one valid: that requester wins.
  - Both valid: the requester not equal to last_grant wins.
  - Neither valid: grant points at ~last_grant.
- reqX_ready_o = can_accept & (grant==X). At most one ready high per cycle. Ready may depend combinationally on valids and rsp_ready_i.
- Handshake (valid & ready) at an edge:
  - load alu_operand1_o/alu_operand2_o/alu_op_o from the winner;
  - latch id_q = winner;
  - last_grant <= winner;
  - state -> EXEC.
- EXEC (exactly one cycle):
  - rsp_data_o <= alu_data_i, rsp_id_o <= id_q, rsp_valid_o <= 1;
  - state -> RESP.
- RESP: rsp_valid_o, rsp_data_o and rsp_id_o are held stable until rsp_ready_i.
  - On the rsp_ready_i edge with a new handshake: state -> EXEC, rsp_valid_o <= 0.
  - On the rsp_ready_i edge without a handshake: state -> IDLE, rsp_valid_o <= 0.
- ALU input registers change only on a handshake. Between transactions they hold their last value.
- Data passes through unmodified; the block never interprets opcodes.

## Timing
- Reset values: state=IDLE, last_grant=1 (requester 0 wins first), alu_operand1_o=0, alu_operand2_o=0, alu_op_o=0, rsp_valid_o=0, rsp_data_o=0, rsp_id_o=0. In IDLE after reset, req0_ready_o=1 and req1_ready_o=0 while neither requester is valid.
- Latency: handshake at edge k -> rsp_valid_o high after edge k+1.
- Throughput: one result per 2 cycles with rsp_ready_i held high, since back-to-back accept happens in RESP.
- Backpressure: rsp_ready_i low keeps state in RESP and both readies low. A requester's valid must stay asserted, with stable payload, until its ready.
- Simultaneous valids on consecutive transactions alternate 0,1,0,1.
- Reset asserted mid-transaction: asynchronous return to reset values. The in-flight request and response are dropped with no response issued.
- No combinational path from alu_data_i to any output.

## Configuration
- ALU_ARB_FIXED_PRIO_EN defined: requester 0 always wins when both are valid. last_grant is still tracked but ignored for arbitration; rsp_id_o is unchanged.
- Undefined (default): round-robin as described above.

## Test plan
- Reset, then req0 only: op1=5, op2=3, op=ADD -> req0_ready_o=1 at accept, rsp_valid_o 2 edges later with rsp_data_o=8, rsp_id_o=0.
- Both valid every cycle, rsp_ready_i=1, req0 op=SUB 10-4, req1 op=XOR 0xF0^0x0F -> responses alternate id 0 (6), id 1 (0xFF), 0, 1. With ALU_ARB_FIXED_PRIO_EN defined: all responses id 0, req1 starved.
- rsp_ready_i held low 5 cycles after a response -> rsp_valid_o, rsp_data_o and rsp_id_o stable for those cycles, both readies 0; rsp_ready_i=1 with req1 valid -> req1 accepted that same edge.
- Neither valid for 3 cycles after a transaction -> state IDLE, alu_operand1_o, alu_operand2_o and alu_op_o unchanged.
- rst_ni pulsed low during EXEC (req1: op1=0x80000000, op2=1, op=SLT) -> all outputs at reset values immediately, no response produced; next request from req0 accepted first.
- Back-to-back stream of 8 req1 ops with req0 idle -> 8 responses, all id 1, spaced exactly 2 cycles apart.

Source files
------------

// File: rtl/alu_share_arb_if.sv
// Bundle of request, ALU-side and response signals around the shared-ALU arbiter.
// The slave modport is the arbiter's view; master is the surrounding pipeline's view.
interface alu_share_arb_if #(
   parameter int DATA_W = 32,
   parameter int OP_W   = 4
);
   logic              req0_valid_i;
   logic              req0_ready_o;
   logic [DATA_W-1:0] req0_op1_i;
   logic [DATA_W-1:0] req0_op2_i;
   logic [OP_W-1:0]   req0_op_i;

   logic              req1_valid_i;
   logic              req1_ready_o;
   logic [DATA_W-1:0] req1_op1_i;
   logic [DATA_W-1:0] req1_op2_i;
   logic [OP_W-1:0]   req1_op_i;

   logic [DATA_W-1:0] alu_operand1_o;
   logic [DATA_W-1:0] alu_operand2_o;
   logic [OP_W-1:0]   alu_op_o;
   logic [DATA_W-1:0] alu_data_i;

   logic              rsp_valid_o;
   logic              rsp_ready_i;
   logic [DATA_W-1:0] rsp_data_o;
   logic              rsp_id_o;

   modport slave (
      input  req0_valid_i, req0_op1_i, req0_op2_i, req0_op_i,
      input  req1_valid_i, req1_op1_i, req1_op2_i, req1_op_i,
      output req0_ready_o, req1_ready_o,
      output alu_operand1_o, alu_operand2_o, alu_op_o,
      input  alu_data_i,
      output rsp_valid_o, rsp_data_o, rsp_id_o,
      input  rsp_ready_i
   );

   modport master (
      output req0_valid_i, req0_op1_i, req0_op2_i, req0_op_i,
      output req1_valid_i, req1_op1_i, req1_op2_i, req1_op_i,
      input  req0_ready_o, req1_ready_o,
      input  alu_operand1_o, alu_operand2_o, alu_op_o,
      output alu_data_i,
      input  rsp_valid_o, rsp_data_o, rsp_id_o,
      output rsp_ready_i
   );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin arbiter/sequencer sharing one ALU between two requesters.
// Define ALU_ARB_FIXED_PRIO_EN to make requester 0 win every tie.
module alu_share_arb #(
   parameter int DATA_W = 32,
   parameter int OP_W   = 4
) (
   input logic             clk_i,
   input logic             rst_ni,
   alu_share_arb_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t            state_q, state_d;
   logic              last_grant_q;
   logic              id_q;
   logic              grant;
   logic              can_accept;
   logic              handshake;
   logic [DATA_W-1:0] op1_q, op2_q, rsp_data_q;
   logic [OP_W-1:0]   op_q;
   logic              rsp_valid_q, rsp_id_q;

   assign can_accept = (state_q == IDLE) || ((state_q == RESP) && bus.rsp_ready_i);

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      grant = ~last_grant_q;
      unique case ({bus.req1_valid_i, bus.req0_valid_i})
         2'b01:   grant = 1'b0;
         2'b10:   grant = 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
         2'b11:   grant = 1'b0;
`else
         2'b11:   grant = ~last_grant_q;
`endif
         default: grant = ~last_grant_q;
      endcase
   end

   assign bus.req0_ready_o = can_accept & ~grant;
   assign bus.req1_ready_o = can_accept &  grant;
   assign handshake = (bus.req0_valid_i & bus.req0_ready_o) |
                      (bus.req1_valid_i & bus.req1_ready_o);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (handshake) state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    if (bus.rsp_ready_i) state_d = handshake ? EXEC : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         id_q         <= 1'b0;
         op1_q        <= '0;
         op2_q        <= '0;
         op_q         <= '0;
      end else begin
         state_q <= state_d;
         if (handshake) begin
            last_grant_q <= grant;
            id_q         <= grant;
            op1_q        <= grant ? bus.req1_op1_i : bus.req0_op1_i;
            op2_q        <= grant ? bus.req1_op2_i : bus.req0_op2_i;
            op_q         <= grant ? bus.req1_op_i  : bus.req0_op_i;
         end
      end
   end

   // Response side: the ALU result is sampled during the single EXEC cycle and
   // then held until the consumer takes it.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_id_q    <= 1'b0;
      end else if (state_q == EXEC) begin
         rsp_valid_q <= 1'b1;
         rsp_data_q  <= bus.alu_data_i;
         rsp_id_q    <= id_q;
      end else if ((state_q == RESP) && bus.rsp_ready_i) begin
         rsp_valid_q <= 1'b0;
      end
   end

   assign bus.alu_operand1_o = op1_q;
   assign bus.alu_operand2_o = op2_q;
   assign bus.alu_op_o       = op_q;
   assign bus.rsp_valid_o    = rsp_valid_q;
   assign bus.rsp_data_o     = rsp_data_q;
   assign bus.rsp_id_o       = rsp_id_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed self-checking bench for alu_share_arb with a small behavioural ALU.
module tb_alu_share_arb;
   localparam int DATA_W = 32;
   localparam int OP_W   = 4;
   localparam logic [OP_W-1:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SLT = 4'd2, OP_XOR = 4'd3;

   logic clk = 1'b0;
   logic rst_ni = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;

   alu_share_arb_if #(.DATA_W(DATA_W), .OP_W(OP_W)) bus ();

   alu_share_arb #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
      .clk_i (clk),
      .rst_ni(rst_ni),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      unique case (bus.alu_op_o)
         OP_ADD:  bus.alu_data_i = bus.alu_operand1_o + bus.alu_operand2_o;
         OP_SUB:  bus.alu_data_i = bus.alu_operand1_o - bus.alu_operand2_o;
         OP_SLT:  bus.alu_data_i = {31'd0, $signed(bus.alu_operand1_o) < $signed(bus.alu_operand2_o)};
         OP_XOR:  bus.alu_data_i = bus.alu_operand1_o ^ bus.alu_operand2_o;
         default: bus.alu_data_i = '0;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [OP_W-1:0] op);
      bus.req0_valid_i = v; bus.req0_op1_i = a; bus.req0_op2_i = b; bus.req0_op_i = op;
   endtask

   task automatic set_req1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [OP_W-1:0] op);
      bus.req1_valid_i = v; bus.req1_op1_i = a; bus.req1_op2_i = b; bus.req1_op_i = op;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_op1"},   bus.alu_operand1_o, 32'd0);
      check({tag, "_op2"},   bus.alu_operand2_o, 32'd0);
      check({tag, "_op"},    {28'd0, bus.alu_op_o}, 32'd0);
      check({tag, "_rspv"},  {31'd0, bus.rsp_valid_o}, 32'd0);
      check({tag, "_rspd"},  bus.rsp_data_o, 32'd0);
      check({tag, "_rspid"}, {31'd0, bus.rsp_id_o}, 32'd0);
      check({tag, "_rdy0"},  {31'd0, bus.req0_ready_o}, 32'd1);
      check({tag, "_rdy1"},  {31'd0, bus.req1_ready_o}, 32'd0);
   endtask

   logic [31:0] exp_id [4];
   logic [31:0] exp_dat[4];
   int          last_cyc;

   initial begin
      set_req0(1'b0, '0, '0, '0);
      set_req1(1'b0, '0, '0, '0);
      bus.rsp_ready_i = 1'b0;
      repeat (2) tick();
      check_reset_vals("rst");
      rst_ni = 1'b1;

      // Single request from req0: 5 + 3
      set_req0(1'b1, 32'd5, 32'd3, OP_ADD);
      bus.rsp_ready_i = 1'b1;
      #1 check("t1_rdy0", {31'd0, bus.req0_ready_o}, 32'd1);
      tick();
      set_req0(1'b0, '0, '0, '0);
      check("t1_alu_op1", bus.alu_operand1_o, 32'd5);
      check("t1_rspv_exec", {31'd0, bus.rsp_valid_o}, 32'd0);
      tick();
      check("t1_rspv", {31'd0, bus.rsp_valid_o}, 32'd1);
      check("t1_data", bus.rsp_data_o, 32'd8);
      check("t1_id", {31'd0, bus.rsp_id_o}, 32'd0);
      tick();
      check("t1_rspv_clr", {31'd0, bus.rsp_valid_o}, 32'd0);

      // Both valid every cycle; req0 won last, so round-robin starts at req1
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_id  = '{32'd0, 32'd0, 32'd0, 32'd0};
      exp_dat = '{32'd6, 32'd6, 32'd6, 32'd6};
`else
      exp_id  = '{32'd1, 32'd0, 32'd1, 32'd0};
      exp_dat = '{32'hFF, 32'd6, 32'hFF, 32'd6};
`endif
      set_req0(1'b1, 32'd10, 32'd4, OP_SUB);
      set_req1(1'b1, 32'hF0, 32'h0F, OP_XOR);
      for (int i = 0; i < 4; i++) begin
         tick();
         tick();
         check($sformatf("t2_rspv%0d", i), {31'd0, bus.rsp_valid_o}, 32'd1);
         check($sformatf("t2_id%0d", i), {31'd0, bus.rsp_id_o}, exp_id[i]);
         check($sformatf("t2_data%0d", i), bus.rsp_data_o, exp_dat[i]);
      end

      // Backpressure for 5 cycles with req1 waiting
      bus.rsp_ready_i = 1'b0;
      set_req0(1'b0, '0, '0, '0);
      set_req1(1'b1, 32'd7, 32'd9, OP_ADD);
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("t3_rspv%0d", i), {31'd0, bus.rsp_valid_o}, 32'd1);
         check($sformatf("t3_data%0d", i), bus.rsp_data_o, exp_dat[3]);
         check($sformatf("t3_id%0d", i), {31'd0, bus.rsp_id_o}, exp_id[3]);
         check($sformatf("t3_rdy%0d", i), {30'd0, bus.req1_ready_o, bus.req0_ready_o}, 32'd0);
      end
      bus.rsp_ready_i = 1'b1;
      #1 check("t3_rdy1_release", {31'd0, bus.req1_ready_o}, 32'd1);
      tick();
      set_req1(1'b0, '0, '0, '0);
      check("t3_alu_op1", bus.alu_operand1_o, 32'd7);
      check("t3_rspv_drop", {31'd0, bus.rsp_valid_o}, 32'd0);
      tick();
      check("t3_data", bus.rsp_data_o, 32'd16);
      check("t3_id", {31'd0, bus.rsp_id_o}, 32'd1);

      // Idle for 3 cycles: ALU inputs hold
      repeat (3) tick();
      check("t4_rspv", {31'd0, bus.rsp_valid_o}, 32'd0);
      check("t4_op1", bus.alu_operand1_o, 32'd7);
      check("t4_op2", bus.alu_operand2_o, 32'd9);
      check("t4_op", {28'd0, bus.alu_op_o}, {28'd0, OP_ADD});
      check("t4_rdy0", {31'd0, bus.req0_ready_o}, 32'd1);
      check("t4_rdy1", {31'd0, bus.req1_ready_o}, 32'd0);

      // Reset pulsed during EXEC
      set_req0(1'b0, '0, '0, '0);
      set_req1(1'b1, 32'h8000_0000, 32'd1, OP_SLT);
      tick();
      set_req1(1'b0, '0, '0, '0);
      check("t5_alu_op1", bus.alu_operand1_o, 32'h8000_0000);
      #2 rst_ni = 1'b0;
      #1 check_reset_vals("t5_async");
      tick();
      check("t5_no_rsp", {31'd0, bus.rsp_valid_o}, 32'd0);
      rst_ni = 1'b1;
      set_req0(1'b1, 32'd1, 32'd2, OP_ADD);
      set_req1(1'b1, 32'd3, 32'd3, OP_SUB);
      #1 check("t5_rdy0", {31'd0, bus.req0_ready_o}, 32'd1);
      check("t5_rdy1", {31'd0, bus.req1_ready_o}, 32'd0);
      tick();
      set_req0(1'b0, '0, '0, '0);
      set_req1(1'b0, '0, '0, '0);
      tick();
      check("t5_id", {31'd0, bus.rsp_id_o}, 32'd0);
      check("t5_data", bus.rsp_data_o, 32'd3);

      // Stream of 8 req1 ops, one result every 2 cycles
      last_cyc = 0;
      for (int i = 0; i < 8; i++) begin
         set_req1(1'b1, i, 32'd100, OP_ADD);
         tick();
         check($sformatf("t6_exec%0d", i), {31'd0, bus.rsp_valid_o}, 32'd0);
         tick();
         check($sformatf("t6_rspv%0d", i), {31'd0, bus.rsp_valid_o}, 32'd1);
         check($sformatf("t6_id%0d", i), {31'd0, bus.rsp_id_o}, 32'd1);
         check($sformatf("t6_data%0d", i), bus.rsp_data_o, 32'd100 + i);
         if (i > 0) check($sformatf("t6_gap%0d", i), cyc - last_cyc, 32'd2);
         last_cyc = cyc;
      end
      set_req1(1'b0, '0, '0, '0);
      tick();
      check("t6_drain", {31'd0, bus.rsp_valid_o}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
